// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle controller: opcodes, ALU/PC
// function codes, FSM states, instruction classes and branch condition codes.
package legv8_ctrl_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [31:0] INSTR_HLT = 32'hD440_0000;

  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_ORR   = 5'b00100;
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;
  localparam logic [4:0] FS_PASSA = 5'b11100;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_OFF  = 2'b10;
  localparam logic [1:0] PS_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH, ST_LOAD_IR, ST_EXEC, ST_MEM, ST_HALTED
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP, CL_ADD, CL_ADDS, CL_SUB, CL_SUBS, CL_AND, CL_ORR, CL_ADDI,
    CL_SUBI, CL_STUR, CL_LDUR, CL_B, CL_CBZ, CL_CBNZ, CL_BCOND, CL_HLT
  } iclass_t;

  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_HS, CC_LO, CC_MI, CC_PL, CC_VS, CC_VC,
    CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
  } cond_t;

  // flags = {V,C,N,Z}
  function automatic logic cond_met(input cond_t cc, input logic [3:0] flags);
    logic v, c, n, z;
    {v, c, n, z} = flags;
    case (cc)
      CC_EQ:   return z;
      CC_NE:   return !z;
      CC_HS:   return c;
      CC_LO:   return !c;
      CC_MI:   return n;
      CC_PL:   return !n;
      CC_VS:   return v;
      CC_VC:   return !v;
      CC_HI:   return c && !z;
      CC_LS:   return !(c && !z);
      CC_GE:   return n == v;
      CC_LT:   return n != v;
      CC_GT:   return !z && (n == v);
      CC_LE:   return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/legv8_instr_decode.sv
// Combinational LEGv8 instruction decoder: class, register fields, extended
// immediates. B.cond is only recognised when LEGV8_BCOND_EN is defined.
module legv8_instr_decode
  import legv8_ctrl_pkg::*;
#(
  parameter int unsigned IW = 32,
  parameter int unsigned KW = 64
) (
  input  logic [IW-1:0] ir,
  output iclass_t       cls,
  output logic [4:0]    rd,
  output logic [4:0]    rn,
  output logic [4:0]    rm,
  output logic [KW-1:0] imm12_z,
  output logic [KW-1:0] imm9_s,
  output logic [KW-1:0] imm19_s,
  output logic [KW-1:0] imm26_s,
  output cond_t         cond
);

  always_comb begin
    rd      = ir[4:0];
    rn      = ir[9:5];
    rm      = ir[20:16];
    imm12_z = {{(KW-12){1'b0}}, ir[21:10]};
    imm9_s  = {{(KW-9){ir[20]}}, ir[20:12]};
    imm19_s = {{(KW-19){ir[23]}}, ir[23:5]};
    imm26_s = {{(KW-26){ir[25]}}, ir[25:0]};
    cond    = cond_t'(ir[3:0]);

    cls = CL_NOP;
    if (ir == INSTR_HLT)            cls = CL_HLT;
    else if (ir[31:21] == OP_ADD)   cls = CL_ADD;
    else if (ir[31:21] == OP_ADDS)  cls = CL_ADDS;
    else if (ir[31:21] == OP_SUB)   cls = CL_SUB;
    else if (ir[31:21] == OP_SUBS)  cls = CL_SUBS;
    else if (ir[31:21] == OP_AND)   cls = CL_AND;
    else if (ir[31:21] == OP_ORR)   cls = CL_ORR;
    else if (ir[31:21] == OP_STUR)  cls = CL_STUR;
    else if (ir[31:21] == OP_LDUR)  cls = CL_LDUR;
    else if (ir[31:22] == OP_ADDI)  cls = CL_ADDI;
    else if (ir[31:22] == OP_SUBI)  cls = CL_SUBI;
    else if (ir[31:26] == OP_B)     cls = CL_B;
    else if (ir[31:24] == OP_CBZ)   cls = CL_CBZ;
    else if (ir[31:24] == OP_CBNZ)  cls = CL_CBNZ;
`ifdef LEGV8_BCOND_EN
    else if (ir[31:24] == OP_BCOND && !ir[4]) cls = CL_BCOND;
`else
    else                            cls = CL_NOP;
`endif
  end

endmodule

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 controller: FETCH -> LOAD_IR -> EXEC (-> MEM) sequencing,
// instruction register, sticky HALT and the combinational datapath control word.
module legv8_control_unit
  import legv8_ctrl_pkg::*;
#(
  parameter int unsigned IW = 32,
  parameter int unsigned KW = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [IW-1:0] INSTR_IN,
  input  logic [3:0]    PRESTAT,
  input  logic          Z_RAW,
  output logic [4:0]    SA,
  output logic [4:0]    SB,
  output logic [4:0]    DA,
  output logic          WR,
  output logic [4:0]    FS,
  output logic          C0,
  output logic [KW-1:0] K,
  output logic          M,
  output logic          EN_ALU,
  output logic          EN_B,
  output logic          EN_PC,
  output logic          EN_ADDR_ALU,
  output logic          EN_ADDR_PC,
  output logic          PC_SEL,
  output logic [1:0]    PS,
  output logic          RCS,
  output logic          RWE,
  output logic          ROE,
  output logic          SFL,
  output logic          HALT
);

  state_t        state_q, state_d;
  logic [IW-1:0] ir_q;
  logic          halt_q;

  iclass_t       cls;
  logic [4:0]    rd, rn, rm;
  logic [KW-1:0] imm12_z, imm9_s, imm19_s, imm26_s;
  cond_t         cond;

  legv8_instr_decode #(.IW(IW), .KW(KW)) u_decode (
    .ir      (ir_q),
    .cls     (cls),
    .rd      (rd),
    .rn      (rn),
    .rm      (rm),
    .imm12_z (imm12_z),
    .imm9_s  (imm9_s),
    .imm19_s (imm19_s),
    .imm26_s (imm26_s),
    .cond    (cond)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_LOAD_IR) ir_q <= INSTR_IN;
      if (state_q == ST_EXEC && cls == CL_HLT) halt_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    SA          = '0;
    SB          = '0;
    DA          = '0;
    WR          = 1'b0;
    FS          = '0;
    C0          = 1'b0;
    K           = '0;
    M           = 1'b0;
    EN_ALU      = 1'b0;
    EN_B        = 1'b0;
    EN_PC       = 1'b0;
    EN_ADDR_ALU = 1'b0;
    EN_ADDR_PC  = 1'b0;
    PC_SEL      = 1'b0;
    PS          = PS_HOLD;
    RCS         = 1'b0;
    RWE         = 1'b0;
    ROE         = 1'b0;
    SFL         = 1'b0;
    HALT        = halt_q && RST;

    if (RST) begin
      case (state_q)
        ST_FETCH: begin
          EN_ADDR_PC = 1'b1;
          RCS        = 1'b1;
          ROE        = 1'b1;
          state_d    = ST_LOAD_IR;
        end
        ST_LOAD_IR: begin
          // PC keeps addressing RAM until its increment lands at the edge
          EN_ADDR_PC = 1'b1;
          RCS        = 1'b1;
          ROE        = 1'b1;
          PS         = PS_INC;
          state_d    = ST_EXEC;
        end
        ST_EXEC: begin
          state_d = ST_FETCH;
          case (cls)
            CL_ADD, CL_ADDS, CL_SUB, CL_SUBS, CL_AND, CL_ORR: begin
              SA     = rn;
              SB     = rm;
              DA     = rd;
              WR     = (rd != 5'd31);
              EN_ALU = 1'b1;
              case (cls)
                CL_AND:  FS = FS_AND;
                CL_ORR:  FS = FS_ORR;
                CL_SUB, CL_SUBS: begin
                  FS = FS_SUB;
                  C0 = 1'b1;
                end
                default: FS = FS_ADD;
              endcase
              SFL = (cls == CL_ADDS) || (cls == CL_SUBS);
            end
            CL_ADDI, CL_SUBI: begin
              SA     = rn;
              DA     = rd;
              WR     = (rd != 5'd31);
              M      = 1'b1;
              K      = imm12_z;
              EN_ALU = 1'b1;
              FS     = (cls == CL_SUBI) ? FS_SUB : FS_ADD;
              C0     = (cls == CL_SUBI);
            end
            CL_STUR: begin
              SA          = rn;
              SB          = rd;
              M           = 1'b1;
              K           = imm9_s;
              FS          = FS_ADD;
              EN_ADDR_ALU = 1'b1;
              EN_B        = 1'b1;
              RCS         = 1'b1;
              RWE         = 1'b1;
            end
            CL_LDUR: begin
              SA          = rn;
              M           = 1'b1;
              K           = imm9_s;
              FS          = FS_ADD;
              EN_ADDR_ALU = 1'b1;
              RCS         = 1'b1;
              ROE         = 1'b1;
              state_d     = ST_MEM;
            end
            CL_B: begin
              PS = PS_OFF;
              K  = imm26_s - KW'(1);
            end
            CL_CBZ, CL_CBNZ: begin
              SA = rd;
              FS = FS_PASSA;
              if (Z_RAW == (cls == CL_CBZ)) begin
                PS = PS_OFF;
                K  = imm19_s - KW'(1);
              end
            end
            CL_BCOND: begin
              if (cond_met(cond, PRESTAT)) begin
                PS = PS_OFF;
                K  = imm19_s - KW'(1);
              end
            end
            CL_HLT:  state_d = ST_HALTED;
            default: ;
          endcase
        end
        ST_MEM: begin
          SA          = rn;
          M           = 1'b1;
          K           = imm9_s;
          FS          = FS_ADD;
          EN_ADDR_ALU = 1'b1;
          RCS         = 1'b1;
          ROE         = 1'b1;
          DA          = rd;
          WR          = (rd != 5'd31);
          state_d     = ST_FETCH;
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_control_unit.sv
// Self-checking bench for legv8_control_unit: instruction vector table with a
// scoreboard queue, hand sequences for HLT and mid-LDUR reset, random bus-rule stream.
module tb_legv8_control_unit;
  import legv8_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] INSTR_IN;
  logic [3:0]  PRESTAT;
  logic        Z_RAW;
  logic [4:0]  SA, SB, DA, FS;
  logic        WR, C0, M, EN_ALU, EN_B, EN_PC, EN_ADDR_ALU, EN_ADDR_PC, PC_SEL;
  logic [63:0] K;
  logic [1:0]  PS;
  logic        RCS, RWE, ROE, SFL, HALT;

  legv8_control_unit #(.IW(32), .KW(64)) dut (
    .CLK(CLK), .RST(RST), .INSTR_IN(INSTR_IN), .PRESTAT(PRESTAT), .Z_RAW(Z_RAW),
    .SA(SA), .SB(SB), .DA(DA), .WR(WR), .FS(FS), .C0(C0), .K(K), .M(M),
    .EN_ALU(EN_ALU), .EN_B(EN_B), .EN_PC(EN_PC), .EN_ADDR_ALU(EN_ADDR_ALU),
    .EN_ADDR_PC(EN_ADDR_PC), .PC_SEL(PC_SEL), .PS(PS), .RCS(RCS), .RWE(RWE),
    .ROE(ROE), .SFL(SFL), .HALT(HALT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  sa, sb, da;
    logic        wr;
    logic [4:0]  fs;
    logic        c0;
    logic [63:0] k;
    logic        m, en_alu, en_b, en_pc, en_addr_alu, en_addr_pc, pc_sel;
    logic [1:0]  ps;
    logic        rcs, rwe, roe, sfl;
  } cw_t;

  typedef struct {
    logic [31:0] instr;
    logic        z;
    logic [3:0]  pst;
    cw_t         ex;
    logic        mem;
    cw_t         mc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  cw_t  CW_FETCH;

  function automatic cw_t get_cw();
    cw_t c;
    c.sa = SA; c.sb = SB; c.da = DA; c.wr = WR; c.fs = FS; c.c0 = C0; c.k = K;
    c.m = M; c.en_alu = EN_ALU; c.en_b = EN_B; c.en_pc = EN_PC;
    c.en_addr_alu = EN_ADDR_ALU; c.en_addr_pc = EN_ADDR_PC; c.pc_sel = PC_SEL;
    c.ps = PS; c.rcs = RCS; c.rwe = RWE; c.roe = ROE; c.sfl = SFL;
    return c;
  endfunction

  function automatic logic [31:0] enc_r(logic [10:0] op, logic [4:0] rm, logic [4:0] rn, logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_i(logic [9:0] op, logic [11:0] imm, logic [4:0] rn, logic [4:0] rd);
    return {op, imm, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(logic [10:0] op, logic [8:0] imm, logic [4:0] rn, logic [4:0] rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_cb(logic [7:0] op, logic [18:0] imm, logic [4:0] rt);
    return {op, imm, rt};
  endfunction

  function automatic vec_t mk(logic [31:0] i, logic z, logic [3:0] p, cw_t e);
    vec_t v;
    v.instr = i; v.z = z; v.pst = p; v.ex = e; v.mem = 1'b0; v.mc = '0;
    return v;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r = $urandom();
    case ($urandom_range(0, 7))
      0:       return {11'b10101011000, r[20:0]};
      1:       return {11'b11111000010, r[20:0]};
      2:       return {11'b11111000000, r[20:0]};
      3:       return {6'b000101, r[25:0]};
      4:       return {8'b10110100, r[23:0]};
      5:       return {8'b01010100, r[23:0]};
      6:       return {10'b1101000100, r[21:0]};
      default: return r;
    endcase
  endfunction

  task automatic check_cw(input string nm, input cw_t got, input cw_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_bits(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Entered one step after the edge that starts a FETCH cycle.
  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    INSTR_IN = v.instr; Z_RAW = v.z; PRESTAT = v.pst;
    #1;
    check_cw($sformatf("fetch[%0d]", idx), get_cw(), CW_FETCH);
    sb.push_back(v);
    tick(); #1;
    check_bits($sformatf("load_ir[%0d]", idx), {58'd0, PS, RCS, ROE, WR, RWE},
               {58'd0, PS_INC, 4'b1100});
    tick(); #1;
    if (sb.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL exec[%0d]: got empty scoreboard expected one entry", idx);
    end else begin
      e = sb.pop_front();
      check_cw($sformatf("exec[%0d]", idx), get_cw(), e.ex);
      if (e.mem) begin
        tick(); #1;
        check_cw($sformatf("mem[%0d]", idx), get_cw(), e.mc);
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    cw_t  bcond_eq, bcond_ge;
    CW_FETCH = '{en_addr_pc: 1'b1, rcs: 1'b1, roe: 1'b1, default: 0};

    vecs.push_back(mk(enc_r(11'b10101011000, 5'd3, 5'd2, 5'd1), 1'b0, 4'h0,
      '{sa: 5'd2, sb: 5'd3, da: 5'd1, wr: 1'b1, fs: FS_ADD, en_alu: 1'b1, sfl: 1'b1, default: 0}));
    vecs.push_back(mk(enc_r(11'b10001011000, 5'd2, 5'd1, 5'd31), 1'b0, 4'h0,
      '{sa: 5'd1, sb: 5'd2, da: 5'd31, fs: FS_ADD, en_alu: 1'b1, default: 0}));
    vecs.push_back(mk(enc_r(11'b11001011000, 5'd6, 5'd5, 5'd4), 1'b0, 4'h0,
      '{sa: 5'd5, sb: 5'd6, da: 5'd4, wr: 1'b1, fs: FS_SUB, c0: 1'b1, en_alu: 1'b1, default: 0}));
    vecs.push_back(mk(enc_r(11'b10001010000, 5'd9, 5'd8, 5'd7), 1'b0, 4'h0,
      '{sa: 5'd8, sb: 5'd9, da: 5'd7, wr: 1'b1, fs: FS_AND, en_alu: 1'b1, default: 0}));
    vecs.push_back(mk(enc_r(11'b10101010000, 5'd12, 5'd11, 5'd10), 1'b0, 4'h0,
      '{sa: 5'd11, sb: 5'd12, da: 5'd10, wr: 1'b1, fs: FS_ORR, en_alu: 1'b1, default: 0}));
    vecs.push_back(mk(enc_r(11'b11101011000, 5'd2, 5'd1, 5'd1), 1'b0, 4'h0,
      '{sa: 5'd1, sb: 5'd2, da: 5'd1, wr: 1'b1, fs: FS_SUB, c0: 1'b1, en_alu: 1'b1, sfl: 1'b1, default: 0}));
    vecs.push_back(mk(enc_i(10'b1001000100, 12'hFFF, 5'd4, 5'd3), 1'b0, 4'h0,
      '{sa: 5'd4, da: 5'd3, wr: 1'b1, m: 1'b1, k: 64'd4095, fs: FS_ADD, en_alu: 1'b1, default: 0}));
    vecs.push_back(mk(enc_i(10'b1101000100, 12'd1, 5'd4, 5'd3), 1'b0, 4'h0,
      '{sa: 5'd4, da: 5'd3, wr: 1'b1, m: 1'b1, k: 64'd1, fs: FS_SUB, c0: 1'b1, en_alu: 1'b1, default: 0}));
    v = mk(enc_d(11'b11111000010, 9'd8, 5'd4, 5'd5), 1'b0, 4'h0,
      '{sa: 5'd4, m: 1'b1, k: 64'd8, fs: FS_ADD, en_addr_alu: 1'b1, rcs: 1'b1, roe: 1'b1, default: 0});
    v.mem = 1'b1;
    v.mc = '{sa: 5'd4, m: 1'b1, k: 64'd8, fs: FS_ADD, en_addr_alu: 1'b1, rcs: 1'b1, roe: 1'b1,
             da: 5'd5, wr: 1'b1, default: 0};
    vecs.push_back(v);
    vecs.push_back(mk(enc_d(11'b11111000000, 9'd16, 5'd4, 5'd5), 1'b0, 4'h0,
      '{sa: 5'd4, sb: 5'd5, m: 1'b1, k: 64'd16, fs: FS_ADD, en_addr_alu: 1'b1, en_b: 1'b1,
        rcs: 1'b1, rwe: 1'b1, default: 0}));
    v = mk(enc_d(11'b11111000010, 9'h1F8, 5'd4, 5'd31), 1'b0, 4'h0,
      '{sa: 5'd4, m: 1'b1, k: 64'hFFFF_FFFF_FFFF_FFF8, fs: FS_ADD, en_addr_alu: 1'b1,
        rcs: 1'b1, roe: 1'b1, default: 0});
    v.mem = 1'b1;
    v.mc = '{sa: 5'd4, m: 1'b1, k: 64'hFFFF_FFFF_FFFF_FFF8, fs: FS_ADD, en_addr_alu: 1'b1,
             rcs: 1'b1, roe: 1'b1, da: 5'd31, default: 0};
    vecs.push_back(v);
    vecs.push_back(mk(enc_cb(8'b10110100, 19'd3, 5'd7), 1'b1, 4'h0,
      '{sa: 5'd7, fs: FS_PASSA, ps: PS_OFF, k: 64'd2, default: 0}));
    vecs.push_back(mk(enc_cb(8'b10110100, 19'd3, 5'd7), 1'b0, 4'h0,
      '{sa: 5'd7, fs: FS_PASSA, default: 0}));
    vecs.push_back(mk(enc_cb(8'b10110101, 19'd3, 5'd7), 1'b0, 4'h0,
      '{sa: 5'd7, fs: FS_PASSA, ps: PS_OFF, k: 64'd2, default: 0}));
    vecs.push_back(mk({6'b000101, 26'h3FF_FFFF}, 1'b0, 4'h0,
      '{ps: PS_OFF, k: 64'hFFFF_FFFF_FFFF_FFFE, default: 0}));
`ifdef LEGV8_BCOND_EN
    bcond_eq = '{ps: PS_OFF, k: 64'd4, default: 0};
    bcond_ge = '{ps: PS_OFF, k: 64'd1, default: 0};
`else
    bcond_eq = '0;
    bcond_ge = '0;
`endif
    vecs.push_back(mk(enc_cb(8'b01010100, 19'd5, 5'd0), 1'b0, 4'b0001, bcond_eq));
    vecs.push_back(mk(enc_cb(8'b01010100, 19'd5, 5'd1), 1'b0, 4'b0001, '0));
    vecs.push_back(mk(enc_cb(8'b01010100, 19'd7, 5'd12), 1'b0, 4'b1000, '0));
    vecs.push_back(mk(enc_cb(8'b01010100, 19'd2, 5'd10), 1'b0, 4'b1010, bcond_ge));
    vecs.push_back(mk(32'h0000_0000, 1'b0, 4'h0, '0));

    RST = 1'b0; INSTR_IN = '0; PRESTAT = '0; Z_RAW = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      check_cw($sformatf("reset_cw[%0d]", i), get_cw(), '0);
      check_bits($sformatf("reset_halt[%0d]", i), {63'd0, HALT}, 64'd0);
    end
    tick();
    RST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Reset lands on the LDUR MEM cycle: no write may escape.
    INSTR_IN = enc_d(11'b11111000010, 9'd8, 5'd4, 5'd5);
    tick(); tick(); tick();
    RST = 1'b0;
    #1;
    check_bits("rst_mem_wr", {63'd0, WR}, 64'd0);
    check_cw("rst_mem_cw", get_cw(), '0);
    tick();
    RST = 1'b1;
    run_vec(100, vecs[0]);

    run_vec(101, mk(32'hD440_0000, 1'b0, 4'h0, '0));
    for (int i = 0; i < 4; i++) begin
      #1;
      check_bits($sformatf("halted_halt[%0d]", i), {63'd0, HALT}, 64'd1);
      check_cw($sformatf("halted_cw[%0d]", i), get_cw(), '0);
      tick();
    end
    RST = 1'b0;
    #1;
    check_bits("halt_in_reset", {63'd0, HALT}, 64'd0);
    tick();
    RST = 1'b1;
    run_vec(102, vecs[2]);

    for (int i = 0; i < 300; i++) begin
      INSTR_IN = rnd_instr();
      Z_RAW = 1'($urandom_range(0, 1));
      PRESTAT = 4'($urandom_range(0, 15));
      #1;
      check_bits($sformatf("bus_rules[%0d]", i),
        {60'd0,
         (32'(EN_ALU) + 32'(EN_B) + 32'(EN_PC) + 32'(ROE)) > 1,
         EN_ADDR_PC && EN_ADDR_ALU,
         RWE && !RCS,
         WR && RWE}, 64'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
